// File: rtl/pipeline_pkg.sv
// Shared types and constants for the IF/ID stall stage.
//   fsm_state_t : fetch-side state (BOOT, RUN, STALL)
//   NOP_INSTR   : encoding loaded into IF/ID on reset and on flush
//   PC_INCR     : sequential PC step
package pipeline_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      STALL = 2'd2
   } fsm_state_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [31:0] PC_INCR   = 32'd4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the optional stall/flush statistics.
// Ports:
//   clk_i : clock
//   inc   : count one event on this edge
//   clear : synchronous clear, takes priority over inc
//   value : current count, sticks at all-ones
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk_i,
   input  logic             inc,
   input  logic             clear,
   output logic [WIDTH-1:0] value
);

   always_ff @(posedge clk_i) begin
      if (clear) begin
         value <= '0;
      end else if (inc && (value != {WIDTH{1'b1}})) begin
         value <= value + 1'b1;
      end
   end

endmodule

// File: rtl/if_id_stall_stage.sv
// Program counter and IF/ID pipeline register with load-use stall and
// branch flush handling.
// Ports:
//   clk_i, rst_i    : clock, synchronous active-low reset
//   stall_i         : load-use stall request (beats flush)
//   flush_i         : branch/jump taken in ID
//   pc_next_i       : next PC from the PC mux
//   instr_i         : instruction memory data for pc_o
//   pc_o            : current PC
//   IF_ID_pc_o      : PC+4 of the instruction in ID
//   IF_ID_instr_o   : instruction in ID
//   IF_ID_valid_o   : ID instruction is real, not a bubble
//   ctrl_bubble_o   : zero the ID/EX control (combinational)
//   stall_cnt_o     : stall-cycle count   (IF_ID_STATS_EN only)
//   flush_cnt_o     : applied-flush count (IF_ID_STATS_EN only)
// Optional feature macro: IF_ID_STATS_EN enables the statistics counters.
//
// state | meaning
// BOOT  | after reset: IF/ID holds a NOP, PC advances, stall/flush ignored
// RUN   | normal advance or flush
// STALL | stall_i seen high: PC and IF/ID hold until stall_i drops
module if_id_stall_stage
   import pipeline_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             stall_i,
   input  logic             flush_i,
   input  logic [31:0]      pc_next_i,
   input  logic [31:0]      instr_i,
   output logic [31:0]      pc_o,
   output logic [31:0]      IF_ID_pc_o,
   output logic [31:0]      IF_ID_instr_o,
   output logic             IF_ID_valid_o,
`ifdef IF_ID_STATS_EN
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o,
`endif
   output logic             ctrl_bubble_o
);

   fsm_state_t state;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state         <= BOOT;
         pc_o          <= RESET_PC;
         IF_ID_pc_o    <= '0;
         IF_ID_instr_o <= NOP_INSTR;
         IF_ID_valid_o <= 1'b0;
      end else begin
         case (state)
            BOOT: begin
               state <= RUN;
               pc_o  <= pc_next_i;
            end
            RUN, STALL: begin
               if (stall_i) begin
                  state <= STALL;
               end else if (flush_i) begin
                  // Fetched instruction is on the wrong path: drop it.
                  state         <= RUN;
                  pc_o          <= pc_next_i;
                  IF_ID_pc_o    <= '0;
                  IF_ID_instr_o <= NOP_INSTR;
                  IF_ID_valid_o <= 1'b0;
               end else begin
                  state         <= RUN;
                  pc_o          <= pc_next_i;
                  IF_ID_pc_o    <= pc_o + PC_INCR;
                  IF_ID_instr_o <= instr_i;
                  IF_ID_valid_o <= 1'b1;
               end
            end
            default: begin
               state <= BOOT;
            end
         endcase
      end
   end

   // The stall must squash ID/EX control in the very cycle it is raised.
   assign ctrl_bubble_o = stall_i | ~IF_ID_valid_o;

`ifdef IF_ID_STATS_EN
   logic active;
   assign active = (state == RUN) || (state == STALL);

   sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
      .clk_i (clk_i),
      .inc   (active && stall_i),
      .clear (~rst_i),
      .value (stall_cnt_o)
   );

   sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
      .clk_i (clk_i),
      .inc   (active && !stall_i && flush_i),
      .clear (~rst_i),
      .value (flush_cnt_o)
   );
`endif

endmodule

// File: tb/tb_if_id_stall_stage.sv
module tb_if_id_stall_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        stall_i = 1'b0;
   logic        flush_i = 1'b0;
   logic [31:0] pc_next_i = '0;
   logic [31:0] instr_i = '0;
   logic [31:0] pc_o, IF_ID_pc_o, IF_ID_instr_o;
   logic        IF_ID_valid_o, ctrl_bubble_o;
`ifdef IF_ID_STATS_EN
   logic [15:0] stall_cnt, flush_cnt;
   logic [31:0] pc2, ifpc2, ifin2;
   logic        val2, bub2;
   logic [1:0]  stall_cnt2, flush_cnt2;
`endif

   always #5 clk_i = ~clk_i;

   if_id_stall_stage #(.RESET_PC(RESET_PC)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .stall_i       (stall_i),
      .flush_i       (flush_i),
      .pc_next_i     (pc_next_i),
      .instr_i       (instr_i),
      .pc_o          (pc_o),
      .IF_ID_pc_o    (IF_ID_pc_o),
      .IF_ID_instr_o (IF_ID_instr_o),
      .IF_ID_valid_o (IF_ID_valid_o),
`ifdef IF_ID_STATS_EN
      .stall_cnt_o   (stall_cnt),
      .flush_cnt_o   (flush_cnt),
`endif
      .ctrl_bubble_o (ctrl_bubble_o)
   );

`ifdef IF_ID_STATS_EN
   if_id_stall_stage #(.RESET_PC(RESET_PC), .CNT_W(2)) dut2 (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .stall_i       (stall_i),
      .flush_i       (flush_i),
      .pc_next_i     (pc_next_i),
      .instr_i       (instr_i),
      .pc_o          (pc2),
      .IF_ID_pc_o    (ifpc2),
      .IF_ID_instr_o (ifin2),
      .IF_ID_valid_o (val2),
      .stall_cnt_o   (stall_cnt2),
      .flush_cnt_o   (flush_cnt2),
      .ctrl_bubble_o (bub2)
   );
`endif

   int pass_cnt = 0;
   int total_cnt = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s actual=%h required=%h", name, act, exp);
   endtask

   // Behavioural model: what the pipeline front end must hold, derived from
   // the priority rules reset > boot-ignore > stall > flush > advance.
   logic [31:0] m_pc, m_ifpc, m_ifin;
   logic        m_val;
   bit          m_boot;
   int          m_stalls, m_flushes;

   always @(posedge clk_i) begin
      if (!rst_i) begin
         m_pc = RESET_PC; m_ifpc = 0; m_ifin = 0; m_val = 0; m_boot = 1;
         m_stalls = 0; m_flushes = 0;
      end else if (m_boot) begin
         m_boot = 0;
         m_pc = pc_next_i;
      end else if (stall_i) begin
         m_stalls++;
      end else if (flush_i) begin
         m_flushes++;
         m_pc = pc_next_i; m_ifpc = 0; m_ifin = 0; m_val = 0;
      end else begin
         m_ifpc = m_pc + 32'd4;
         m_ifin = instr_i;
         m_val  = 1;
         m_pc   = pc_next_i;
      end
   end

   function automatic logic [31:0] sat(input int n, input int w);
      int mx = (1 << w) - 1;
      return (n > mx) ? mx : n;
   endfunction

   always @(negedge clk_i) begin
      if (chk_en) begin
         check("pc", pc_o, m_pc);
         check("ifid_pc", IF_ID_pc_o, m_ifpc);
         check("ifid_instr", IF_ID_instr_o, m_ifin);
         check("valid", {31'd0, IF_ID_valid_o}, {31'd0, m_val});
         check("bubble", {31'd0, ctrl_bubble_o}, {31'd0, stall_i | ~m_val});
`ifdef IF_ID_STATS_EN
         check("stall_cnt", {16'd0, stall_cnt}, sat(m_stalls, 16));
         check("flush_cnt", {16'd0, flush_cnt}, sat(m_flushes, 16));
         check("stall_cnt_w2", {30'd0, stall_cnt2}, sat(m_stalls, 2));
         check("flush_cnt_w2", {30'd0, flush_cnt2}, sat(m_flushes, 2));
`endif
      end
   end

   task automatic step(input logic r, input logic s, input logic f,
                       input logic [31:0] pn, input logic [31:0] in);
      rst_i = r; stall_i = s; flush_i = f; pc_next_i = pn; instr_i = in;
      @(posedge clk_i);
      #1;
   endtask

   // Sequential fetch: next PC is the bench's own view of PC+4.
   task automatic seq(input logic s, input logic [31:0] in);
      step(1'b1, s, 1'b0, m_pc + 32'd4, in);
   endtask

   initial begin
      #1;
      // Reset held for 3 cycles
      step(0, 0, 0, 32'h0, 32'h0);
      chk_en = 1'b1;
      step(0, 1, 1, 32'h0, 32'h0);
      step(0, 0, 0, 32'h0, 32'h0);
      check("lit_reset_pc", pc_o, RESET_PC);
      check("lit_reset_valid", {31'd0, IF_ID_valid_o}, 32'd0);
      check("lit_reset_bubble", {31'd0, ctrl_bubble_o}, 32'd1);

      // BOOT edge: stall/flush ignored, PC still advances
      step(1, 1, 1, 32'h4, 32'h8C08_0000);
      check("lit_boot_pc", pc_o, 32'h4);
      check("lit_boot_valid", {31'd0, IF_ID_valid_o}, 32'd0);

      // Straight-line
      seq(0, 32'h8C08_0000);
      check("lit_run_ifpc", IF_ID_pc_o, 32'h8);
      check("lit_run_instr", IF_ID_instr_o, 32'h8C08_0000);
      check("lit_run_valid", {31'd0, IF_ID_valid_o}, 32'd1);
      seq(0, 32'h0109_5020);
      check("lit_run_ifpc2", IF_ID_pc_o, 32'hC);
      check("lit_run_instr2", IF_ID_instr_o, 32'h0109_5020);

      // Single-cycle stall
      seq(1, 32'hDEAD_BEEF);
      check("lit_stall_pc", pc_o, 32'hC);
      check("lit_stall_instr", IF_ID_instr_o, 32'h0109_5020);
      seq(0, 32'h2222_0000);
      check("lit_stall_rel_pc", pc_o, 32'h10);
      check("lit_stall_rel_ifpc", IF_ID_pc_o, 32'h10);

      // Flush
      step(1, 0, 1, 32'h40, 32'h3333_0000);
      check("lit_flush_pc", pc_o, 32'h40);
      check("lit_flush_instr", IF_ID_instr_o, 32'h0);
      check("lit_flush_bubble", {31'd0, ctrl_bubble_o}, 32'd1);
      seq(0, 32'h4444_0000);
      seq(0, 32'h5555_0000);

      // Stall+flush for 2 cycles, then flush only
      step(1, 1, 1, 32'h80, 32'h6666_0000);
      step(1, 1, 1, 32'h80, 32'h6666_0000);
      check("lit_sf_pc_hold", pc_o, 32'h48);
      check("lit_sf_valid_hold", {31'd0, IF_ID_valid_o}, 32'd1);
      step(1, 0, 1, 32'h80, 32'h6666_0000);
      check("lit_sf_release_pc", pc_o, 32'h80);
      check("lit_sf_release_valid", {31'd0, IF_ID_valid_o}, 32'd0);
      seq(0, 32'h7777_0000);

      // PC+4 wraps modulo 2^32
      step(1, 0, 0, 32'hFFFF_FFFC, 32'h1111_0000);
      seq(0, 32'h9999_0000);
      check("lit_wrap_ifpc", IF_ID_pc_o, 32'h0);
      check("lit_wrap_pc", pc_o, 32'h0);

      // Reset during a long stall
      seq(1, 32'h0); seq(1, 32'h0); seq(1, 32'h0);
      step(0, 1, 0, 32'h100, 32'h0);
      check("lit_rst_stall_pc", pc_o, RESET_PC);
      check("lit_rst_stall_valid", {31'd0, IF_ID_valid_o}, 32'd0);
      step(1, 1, 0, 32'h4, 32'h0);   // BOOT ignores the stall still held
      check("lit_rst_boot_pc", pc_o, 32'h4);

      // Five separate stalls for counter saturation in the narrow build
      for (int i = 0; i < 5; i++) begin
         seq(1, 32'h0);
         seq(0, 32'hA000_0000 + i);
      end
`ifdef IF_ID_STATS_EN
      check("lit_sat_w2", {30'd0, stall_cnt2}, 32'd3);
      check("lit_cnt_w16", {16'd0, stall_cnt}, 32'd5);
`endif
      seq(0, 32'h0);
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
